mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequencer between the pipeline's MEM stage and a single-port, word-wide data memory with synchronous read. Executes LW/LH/LHU/LB/LBU/SW/SH/SB over a req/done handshake. Performs byte/half-lane extraction with sign/zero extension for loads. Performs read-modify-write for sub-word stores, so the memory only ever sees full-word accesses.

Parameters:
ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  synchronous, active-high reset
Req  input  1  request strobe; sampled only while Busy=0
Write  input  1  1=store, 0=load
Size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
Unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend
Addr  input  ADDR_W  byte address
WrData  input  32  store data, LS byte/half used for SB/SH
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle completion pulse
Err  output  1  valid with Done; misaligned or reserved size
RdData  output  32  load result, valid with Done, held until next Done
MemAddr  output  ADDR_W-2  word address, Addr[ADDR_W-1:2] latched
MemRe  output  1  memory read enable
MemWe  output  1  memory write enable
MemWrData  output  32  full word written
MemRdData  input  32  read data, valid the cycle after MemRe

Behaviour:
- Reset (Rst=1 at edge): state=IDLE; Busy=0, Done=0, Err=0, RdData=0, MemRe=0, MemWe=0, MemWrData=0. Latched request fields are cleared.
- MemWe is gated with !Rst. A WRITE-state cycle coinciding with Rst produces no memory write.
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- IDLE: if Req, latch Write/Size/Unsigned/Addr/WrData.
  - Misaligned request (half with Addr[0]=1, word with Addr[1:0]!=0, Size=3) -> DONE with Err=1, no memory access.
  - SW -> WRITE.
  - Everything else -> READ.
- READ: MemRe=1 for exactly one cycle -> CAPTURE.
- CAPTURE: MemRdData sampled.
  - Load: extract the lane, extend, register into RdData -> DONE.
  - Sub-word store: merge into a MemWrData register -> WRITE.
- WRITE: MemWe=1 for exactly one cycle with MemWrData -> DONE.
- DONE: Done=1 for one cycle, Busy=1 -> IDLE. A Req arriving in DONE is ignored; the requester holds Req until Busy=0.
- Latency, with Req accepted at edge T:
  - Misaligned: Done in cycle T+1.
  - SW: Done in cycle T+2.
  - Load: Done in cycle T+3.
  - SB/SH: Done in cycle T+4.
- Lane map (little-endian):
  - Byte offset 0..3 selects bits [7:0], [15:8], [23:16], [31:24].
  - Half offset 0 selects [15:0]; offset 2 selects [31:16].
- Loads: the selected byte/half goes to the LSBs; upper bits are 0 when Unsigned=1, else copies of the lane MSB. Word load returns MemRdData unchanged, and Unsigned is ignored.
- Stores: only the selected lane is replaced, with WrData[7:0] or WrData[15:0]; other lanes keep their MemRdData values.
- Err=0 and RdData unchanged on stores. On a misaligned access RdData is unchanged.
- MemAddr is driven from the latched address in all non-IDLE states and holds its value in IDLE.
- Mid-operation reset: abort to IDLE. No Done pulse, no write.

Decomposition:
- Package mem_access_pkg: Size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding, lane-offset constants.
- Sub-module byte_lane_unit: purely combinational. Takes offset, size, unsigned, mem word and store data; outputs the extracted/extended load value and the merged store word. The FSM instantiates it once.

Test Plan:
- Mem word 0x8844_22F1; LB Addr=0x100 -> RdData=0xFFFF_FFF1, Done at T+3. LBU Addr=0x103 -> 0x0000_0088.
- Mem word 0x8844_22F1; LH Addr=0x102 -> 0xFFFF_8844. LHU Addr=0x100 -> 0x0000_22F1. LW -> 0x8844_22F1.
- Mem word 0x1122_3344; SB Addr=0x201, WrData=0xAAAA_AA5A:
  - MemRe at T+1, MemWe at T+3 with MemWrData=0x1122_5A44.
  - Done at T+4.
- SW Addr=0x204, WrData=0xDEAD_BEEF -> MemWe at T+1, word address 0x81, Done at T+2, MemRe never asserted.
- LH Addr=0x101 and LW Addr=0x102 -> Done+Err at T+1, MemRe=MemWe=0, RdData unchanged.
- SH Addr=0x300, Rst asserted during the WRITE cycle -> MemWe never seen high at an edge, no Done, Busy=0 next cycle. A new LW is accepted immediately afterwards and completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access sequencer.
//   size_e  : access width encoding carried on the Size port
//   state_e : sequencer states
//   OFF_*   : byte-offset values selecting byte and half-word lanes
//   is_misaligned : flags accesses that must complete with an error
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic [1:0] OFF_B0   = 2'd0;
  localparam logic [1:0] OFF_B1   = 2'd1;
  localparam logic [1:0] OFF_B2   = 2'd2;
  localparam logic [1:0] OFF_B3   = 2'd3;
  localparam logic [1:0] OFF_H_HI = 2'd2;

  // Reserved size is always rejected; half needs even, word needs 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b1;
    if (size == SZ_BYTE)      mis = 1'b0;
    else if (size == SZ_HALF) mis = off[0];
    else if (size == SZ_WORD) mis = (off != 2'd0);
    return mis;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane steering for sub-word accesses (little-endian).
// Ports:
//   offset      : byte offset within the word (Addr[1:0])
//   size        : access width (size_e encoding)
//   is_unsigned : loads only, 1 = zero-extend, 0 = sign-extend
//   mem_word    : word read from memory
//   st_data     : store data, LS byte/half used for sub-word stores
//   ld_val      : extracted and extended load value
//   st_word     : mem_word with the addressed lane replaced by store data
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] mem_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_val,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = mem_word[7:0];
    case (offset)
      OFF_B0:  ld_byte = mem_word[7:0];
      OFF_B1:  ld_byte = mem_word[15:8];
      OFF_B2:  ld_byte = mem_word[23:16];
      OFF_B3:  ld_byte = mem_word[31:24];
      default: ld_byte = mem_word[7:0];
    endcase
    ld_half = (offset == OFF_H_HI) ? mem_word[31:16] : mem_word[15:0];

    // Word accesses pass straight through in both directions.
    ld_val  = mem_word;
    st_word = st_data;
    if (size == SZ_BYTE) begin
      ld_val  = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      st_word = mem_word;
      case (offset)
        OFF_B0:  st_word[7:0]   = st_data[7:0];
        OFF_B1:  st_word[15:8]  = st_data[7:0];
        OFF_B2:  st_word[23:16] = st_data[7:0];
        OFF_B3:  st_word[31:24] = st_data[7:0];
        default: st_word[7:0]   = st_data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      ld_val  = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      st_word = mem_word;
      if (offset == OFF_H_HI) st_word[31:16] = st_data[15:0];
      else                    st_word[15:0]  = st_data[15:0];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between the MEM stage and a single-port, word-wide memory with
// synchronous read. Sub-word stores are done as read-modify-write so the
// memory only ever sees full-word accesses.
// Ports:
//   Clk, Rst          : clock, synchronous active-high reset
//   Req/Write/Size/Unsigned/Addr/WrData : request, sampled only while Busy=0
//   Busy, Done, Err   : handshake status; Err is valid with Done
//   RdData            : load result, held until the next completed load
//   MemAddr/MemRe/MemWe/MemWrData/MemRdData : memory interface
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  input  logic              Write,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [31:0]       RdData,
  output logic [ADDR_W-3:0] MemAddr,
  output logic              MemRe,
  output logic              MemWe,
  output logic [31:0]       MemWrData,
  input  logic [31:0]       MemRdData
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [31:0]       mem_wr_data_q, mem_wr_data_d;

  logic [31:0]       ld_val;
  logic [31:0]       st_word;

  byte_lane_unit u_lane (
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .mem_word    (MemRdData),
    .st_data     (wdata_q),
    .ld_val      (ld_val),
    .st_word     (st_word)
  );

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    uns_d         = uns_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    rd_data_d     = rd_data_q;
    mem_wr_data_d = mem_wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Req) begin
          write_d = Write;
          size_d  = Size;
          uns_d   = Unsigned;
          addr_d  = Addr;
          wdata_d = WrData;
          if (is_misaligned(Size, Addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (Write && (Size == SZ_WORD)) begin
            // Full-word store needs no read; the word is ready now.
            err_d         = 1'b0;
            mem_wr_data_d = WrData;
            state_d       = ST_WRITE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_READ;
          end
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        // MemRdData is valid this cycle (one cycle after MemRe).
        if (write_q) begin
          mem_wr_data_d = st_word;
          state_d       = ST_WRITE;
        end else begin
          rd_data_d = ld_val;
          state_d   = ST_DONE;
        end
      end
      ST_WRITE:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'd0;
      uns_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      err_q         <= 1'b0;
      rd_data_q     <= 32'd0;
      mem_wr_data_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);
  assign Err       = (state_q == ST_DONE) && err_q;
  assign MemRe     = (state_q == ST_READ);
  // Gated so a write cycle that coincides with reset never reaches memory.
  assign MemWe     = (state_q == ST_WRITE) && !Rst;
  assign MemWrData = mem_wr_data_q;
  assign RdData    = rd_data_q;
  assign MemAddr   = addr_q[ADDR_W-1:2];

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: bench-owned synchronous memory,
// directed literal cases, then randomized requests against a behavioural model.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req = 1'b0;
  logic        Write = 1'b0;
  logic [1:0]  Size = 2'd0;
  logic        Unsigned = 1'b0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WrData = 32'd0;
  logic        Busy, Done, Err, MemRe, MemWe;
  logic [31:0] RdData, MemWrData, MemRdData;
  logic [29:0] MemAddr;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Write(Write), .Size(Size),
    .Unsigned(Unsigned), .Addr(Addr), .WrData(WrData), .Busy(Busy),
    .Done(Done), .Err(Err), .RdData(RdData), .MemAddr(MemAddr),
    .MemRe(MemRe), .MemWe(MemWe), .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  // Bench memory: synchronous read, 256 words.
  logic [31:0] dmem [256];
  logic [31:0] mem_rd_q = 32'd0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = 8'd0;
  logic [31:0] pl_d = 32'd0;
  always @(posedge Clk) begin
    if (pl_en) dmem[pl_a] <= pl_d;
    if (MemWe) dmem[MemAddr[7:0]] <= MemWrData;
    if (MemRe) mem_rd_q <= dmem[MemAddr[7:0]];
  end
  assign MemRdData = mem_rd_q;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0] ref_mem [256];
  int          nchk = 0, nerr = 0;
  int          t_t = -100, t_l = 0, re_c = -1, we_c = -1, cut = 1 << 30, rd_c = 0;
  logic        t_err = 1'b0;
  logic [31:0] we_d = 0, rd_old = 0, rd_new = 0, exp_rd_now = 0;
  logic [29:0] t_wa = 0;
  bit          chk_en = 1'b0;

  // Observations of the DUT for timing checks
  int          last_done_c = -1, last_re_c = -1, last_we_c = -1;
  int          cnt_re = 0, cnt_we = 0, cnt_done = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_we_d = 0;
  logic [29:0] last_we_a = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, int sz, int off, bit uns);
    logic [31:0] v, mask;
    int bits;
    if (sz == 2) return w;
    bits = (sz == 0) ? 8 : 16;
    mask = (32'd1 << bits) - 32'd1;
    v = (w >> (8 * off)) & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] w, int sz, int off, logic [31:0] d);
    logic [31:0] mask;
    mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (w & ~mask) | ((d << (8 * off)) & mask);
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    pl_en = 1'b1; pl_a = idx[7:0]; pl_d = d;
    @(posedge Clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic junk();
    Req = 1'($urandom); Write = 1'($urandom); Size = 2'($urandom);
    Unsigned = 1'($urandom); Addr = $urandom; WrData = $urandom;
  endtask

  // Issue one request; rst_at>=0 pulses Rst in cycle t+rst_at.
  task automatic issue(input bit wr, input int sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input int rst_at, output int t);
    int off, n;
    bit mis;
    logic [31:0] word;
    n = 0;
    while (Busy && n < 10) begin @(posedge Clk); #1; n++; end
    if (Busy) chk("issue_timeout", 32'(Busy), 32'd0);
    t    = cyc;
    off  = int'(a[1:0]);
    mis  = (sz == 3) || ((off % (1 << sz)) != 0);
    word = ref_mem[a[9:2]];
    t_l  = mis ? 1 : (wr && sz == 2) ? 2 : !wr ? 3 : 4;
    t_t  = t; t_err = mis; cut = 1 << 30; t_wa = a[31:2];
    re_c = (!mis && !(wr && sz == 2)) ? t + 1 : -1;
    we_c = (wr && !mis) ? t + t_l - 1 : -1;
    we_d = (sz == 2) ? wd : m_store(word, sz, off, wd);
    rd_old = exp_rd_now;
    rd_new = (!wr && !mis) ? m_load(word, sz, off, uns) : exp_rd_now;
    rd_c = t + 3;
    Req = 1'b1; Write = wr; Size = sz[1:0]; Unsigned = uns; Addr = a; WrData = wd;
    @(posedge Clk); #1;
    Req = 1'b0;
    while (cyc <= t + t_l && cyc <= cut) begin
      junk();
      if (rst_at >= 0 && cyc == t + rst_at) begin
        Rst = 1'b1; cut = cyc;
        rd_old = exp_rd_now; rd_new = 32'd0; rd_c = cyc + 1;
      end
      @(posedge Clk); #1;
      Rst = 1'b0;
    end
    Req = 1'b0;
    if (wr && !mis && we_c < cut) ref_mem[a[9:2]] = we_d;
    exp_rd_now = rd_new;
  endtask

  int t, c_re, c_we, c_done;

  initial begin
    fork
      forever begin
        @(negedge Clk);
        if (chk_en) begin
          bit e_busy, e_done, e_re, e_we;
          e_busy = (cyc > t_t) && (cyc <= t_t + t_l) && (cyc <= cut);
          e_done = (cyc == t_t + t_l) && (cyc <= cut);
          e_re   = (cyc == re_c) && (cyc <= cut);
          e_we   = (cyc == we_c) && (cyc < cut);
          chk("busy", 32'(Busy), 32'(e_busy));
          chk("done", 32'(Done), 32'(e_done));
          chk("err", 32'(Err), 32'(e_done && t_err));
          chk("mem_re", 32'(MemRe), 32'(e_re));
          chk("mem_we", 32'(MemWe), 32'(e_we));
          chk("rd_data", RdData, (cyc >= rd_c) ? rd_new : rd_old);
          if (e_busy) chk("mem_addr", 32'(MemAddr), 32'(t_wa));
          if (e_we) chk("mem_wr_data", MemWrData, we_d);
        end
        if (Done)  begin last_done_c = cyc; last_err = Err; cnt_done++; end
        if (MemRe) begin last_re_c = cyc; cnt_re++; end
        if (MemWe) begin last_we_c = cyc; last_we_d = MemWrData; last_we_a = MemAddr; cnt_we++; end
      end
    join_none

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_rd", RdData, 32'd0);
    chk("rst_re", 32'(MemRe), 32'd0);
    chk("rst_we", 32'(MemWe), 32'd0);
    chk("rst_wrdata", MemWrData, 32'd0);
    chk("rst_addr", 32'(MemAddr), 32'd0);
    Rst = 1'b0;

    for (int i = 0; i < 256; i++) preload(i, $urandom);
    preload(8'h40, 32'h8844_22F1);
    preload(8'h80, 32'h1122_3344);
    preload(8'hC0, 32'hCAFE_F00D);
    chk_en = 1'b1;

    // Model pins
    chk("model_lb", m_load(32'h8844_22F1, 0, 0, 1'b0), 32'hFFFF_FFF1);
    chk("model_sb", m_store(32'h1122_3344, 0, 1, 32'hAAAA_AA5A), 32'h1122_5A44);

    // Loads
    issue(0, 0, 0, 32'h100, 0, -1, t);
    chk("lb_rd", RdData, 32'hFFFF_FFF1);
    chk("lb_lat", 32'(last_done_c - t), 32'd3);
    issue(0, 0, 1, 32'h103, 0, -1, t);
    chk("lbu_rd", RdData, 32'h0000_0088);
    issue(0, 1, 0, 32'h102, 0, -1, t);
    chk("lh_rd", RdData, 32'hFFFF_8844);
    issue(0, 1, 1, 32'h100, 0, -1, t);
    chk("lhu_rd", RdData, 32'h0000_22F1);
    issue(0, 2, 0, 32'h100, 0, -1, t);
    chk("lw_rd", RdData, 32'h8844_22F1);

    // Sub-word store
    issue(1, 0, 0, 32'h201, 32'hAAAA_AA5A, -1, t);
    chk("sb_re_t", 32'(last_re_c - t), 32'd1);
    chk("sb_we_t", 32'(last_we_c - t), 32'd3);
    chk("sb_we_d", last_we_d, 32'h1122_5A44);
    chk("sb_done_t", 32'(last_done_c - t), 32'd4);
    issue(0, 2, 0, 32'h200, 0, -1, t);
    chk("sb_readback", RdData, 32'h1122_5A44);

    // Full-word store
    c_re = cnt_re;
    issue(1, 2, 0, 32'h204, 32'hDEAD_BEEF, -1, t);
    chk("sw_we_t", 32'(last_we_c - t), 32'd1);
    chk("sw_we_a", 32'(last_we_a), 32'h81);
    chk("sw_done_t", 32'(last_done_c - t), 32'd2);
    chk("sw_no_re", 32'(cnt_re - c_re), 32'd0);

    // Misaligned
    c_re = cnt_re; c_we = cnt_we;
    issue(0, 1, 0, 32'h101, 0, -1, t);
    chk("mis_lh_err", 32'(last_err), 32'd1);
    chk("mis_lh_t", 32'(last_done_c - t), 32'd1);
    chk("mis_lh_rd", RdData, 32'h1122_5A44);
    issue(0, 2, 0, 32'h102, 0, -1, t);
    chk("mis_lw_err", 32'(last_err), 32'd1);
    chk("mis_lw_t", 32'(last_done_c - t), 32'd1);
    chk("mis_no_mem", 32'((cnt_re - c_re) + (cnt_we - c_we)), 32'd0);

    // Reset during the WRITE cycle of an SH
    c_we = cnt_we; c_done = cnt_done;
    issue(1, 1, 0, 32'h300, 32'h0000_1234, 3, t);
    chk("rst_sh_no_we", 32'(cnt_we - c_we), 32'd0);
    chk("rst_sh_no_done", 32'(cnt_done - c_done), 32'd0);
    chk("rst_sh_idle", 32'(Busy), 32'd0);
    issue(0, 2, 0, 32'h300, 0, -1, t);
    chk("rst_lw_rd", RdData, 32'hCAFE_F00D);
    chk("rst_lw_t", 32'(last_done_c - t), 32'd3);

    // Randomized traffic over a small region so stores and loads overlap
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        Req = 1'b0;
        @(posedge Clk); #1;
      end
      issue(1'($urandom), $urandom_range(0, 3), 1'($urandom),
            32'($urandom_range(0, 255)), $urandom, -1, t);
    end

    repeat (2) @(posedge Clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
